// File: rtl/blackparrot_fpga_host_io_out.sv
// blackparrot_fpga_host_io_out
// AXI4 subordinate on BlackParrot's I/O-out port. Each single-beat write is
// packed into an NBF record {opcode, addr, data}. The record is sent to the
// host as five 32b flits, LSB first. Bursts are drained and answered with
// SLVERR. Reads are answered locally with zero data.
module blackparrot_fpga_host_io_out #(
    parameter int S_AXI_ADDR_WIDTH   = 64,
    parameter int S_AXI_DATA_WIDTH   = 64,
    parameter int S_AXI_ID_WIDTH     = 4,
    parameter int fifo_data_width_p  = 32,
    parameter int nbf_opcode_width_p = 8,
    parameter int nbf_addr_width_p   = 64,
    parameter int nbf_data_width_p   = 64
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,

    input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic                          s_axi_awlock,
    input  logic [3:0]                    s_axi_awcache,
    input  logic [2:0]                    s_axi_awprot,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic [1:0]                    s_axi_awburst,
    input  logic [3:0]                    s_axi_awqos,
    input  logic [3:0]                    s_axi_awregion,

    input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    input  logic                          s_axi_wlast,
    input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,

    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    output logic [S_AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                    s_axi_bresp,

    input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic                          s_axi_arlock,
    input  logic [3:0]                    s_axi_arcache,
    input  logic [2:0]                    s_axi_arprot,
    input  logic [7:0]                    s_axi_arlen,
    input  logic [2:0]                    s_axi_arsize,
    input  logic [1:0]                    s_axi_arburst,
    input  logic [3:0]                    s_axi_arqos,
    input  logic [3:0]                    s_axi_arregion,

    output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [S_AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic                          s_axi_rlast,
    output logic [1:0]                    s_axi_rresp,

    output logic                          io_v_o,
    output logic [fifo_data_width_p-1:0]  io_data_o,
    input  logic                          io_ready_and_i
);

    typedef enum logic [2:0] {IDLE, DRAIN, SEND, BRESP, RRESP} state_e;

    state_e                        state_r, state_n;
    logic                          active_r;
    logic                          aw_full_r, w_full_r;
    logic [S_AXI_ID_WIDTH-1:0]     aw_id_r, ar_id_r;
    logic [S_AXI_ADDR_WIDTH-1:0]   aw_addr_r;
    logic [7:0]                    aw_len_r;
    logic [2:0]                    aw_size_r;
    logic [S_AXI_DATA_WIDTH-1:0]   w_data_r;
    logic                          w_last_r;
    logic [2:0]                    flit_cnt_r, flit_cnt_n;
    logic [1:0]                    bresp_r, bresp_n;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, flit_hs;
    logic aw_have, w_have, cur_last;
    logic [7:0] cur_len;

    logic [nbf_opcode_width_p-1:0] rec_opcode;
    logic [nbf_data_width_p-1:0]   rec_data;
    logic [nbf_addr_width_p-1:0]   rec_addr;

    // Sideband fields this block never looks at
    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                         s_axi_awburst, s_axi_awqos, s_axi_awregion, s_axi_wstrb,
                         s_axi_araddr, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                         s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arqos,
                         s_axi_arregion};

    // Ready signals stay low until the first clock after reset is released.
    // Reads are accepted only when no write is held or being offered.
    assign s_axi_awready = active_r & (state_r == IDLE) & ~aw_full_r;
    assign s_axi_wready  = active_r & (((state_r == IDLE) & ~w_full_r) | (state_r == DRAIN));
    assign s_axi_arready = active_r & (state_r == IDLE) & ~aw_full_r & ~w_full_r
                         & ~s_axi_awvalid & ~s_axi_wvalid;

    assign aw_hs   = s_axi_awvalid & s_axi_awready;
    assign w_hs    = s_axi_wvalid  & s_axi_wready;
    assign ar_hs   = s_axi_arvalid & s_axi_arready;
    assign b_hs    = s_axi_bvalid  & s_axi_bready;
    assign r_hs    = s_axi_rvalid  & s_axi_rready;
    assign flit_hs = io_v_o & io_ready_and_i;

    // A write is complete as soon as both halves are held or arriving this cycle
    assign aw_have  = aw_full_r | aw_hs;
    assign w_have   = w_full_r  | (w_hs & (state_r == IDLE));
    assign cur_len  = aw_full_r ? aw_len_r : s_axi_awlen;
    assign cur_last = w_full_r  ? w_last_r : s_axi_wlast;

    assign s_axi_bvalid = (state_r == BRESP);
    assign s_axi_bid    = aw_id_r;
    assign s_axi_bresp  = bresp_r;
    assign s_axi_rvalid = (state_r == RRESP);
    assign s_axi_rdata  = '0;
    assign s_axi_rresp  = 2'b00;
    assign s_axi_rlast  = (state_r == RRESP);
    assign s_axi_rid    = ar_id_r;
    assign io_v_o       = (state_r == SEND);

    // Next-state logic for the transaction FSM
    always_comb begin
        state_n    = state_r;
        flit_cnt_n = flit_cnt_r;
        bresp_n    = bresp_r;
        case (state_r)
            IDLE: begin
                if (aw_have && w_have) begin
                    if (cur_len == 8'd0) begin
                        state_n    = SEND;
                        flit_cnt_n = 3'd0;
                        bresp_n    = 2'b00;
                    end else if (!cur_last) begin
                        state_n = DRAIN;
                    end else begin
                        state_n = BRESP;
                        bresp_n = 2'b10;
                    end
                end else if (ar_hs) begin
                    state_n = RRESP;
                end
            end
            DRAIN: begin
                if (w_hs && s_axi_wlast) begin
                    state_n = BRESP;
                    bresp_n = 2'b10;
                end
            end
            SEND: begin
                if (flit_hs) begin
                    if (flit_cnt_r == 3'd4) begin
                        state_n    = BRESP;
                        flit_cnt_n = 3'd0;
                        bresp_n    = 2'b00;
                    end else begin
                        flit_cnt_n = flit_cnt_r + 3'd1;
                    end
                end
            end
            BRESP: begin
                if (b_hs) state_n = IDLE;
            end
            RRESP: begin
                if (r_hs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state, flit counter and response code registers
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_r    <= IDLE;
            flit_cnt_r <= 3'd0;
            bresp_r    <= 2'b00;
            active_r   <= 1'b0;
        end else begin
            state_r    <= state_n;
            flit_cnt_r <= flit_cnt_n;
            bresp_r    <= bresp_n;
            active_r   <= 1'b1;
        end
    end

    // Holding registers for AW, W and AR. They are freed when B completes.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_full_r <= 1'b0;
            w_full_r  <= 1'b0;
            aw_id_r   <= '0;
            aw_addr_r <= '0;
            aw_len_r  <= 8'd0;
            aw_size_r <= 3'd0;
            w_data_r  <= '0;
            w_last_r  <= 1'b0;
            ar_id_r   <= '0;
        end else begin
            if (aw_hs) begin
                aw_full_r <= 1'b1;
                aw_id_r   <= s_axi_awid;
                aw_addr_r <= s_axi_awaddr;
                aw_len_r  <= s_axi_awlen;
                aw_size_r <= s_axi_awsize;
            end else if (b_hs) begin
                aw_full_r <= 1'b0;
            end
            if (w_hs && (state_r == IDLE)) begin
                w_full_r <= 1'b1;
                w_data_r <= s_axi_wdata;
                w_last_r <= s_axi_wlast;
            end else if (b_hs) begin
                w_full_r <= 1'b0;
            end
            if (ar_hs) ar_id_r <= s_axi_arid;
        end
    end

    // NBF record fields: the opcode is the size code, saturated at 3.
    // The data field is the addressed lane, zero-extended.
    always_comb begin
        rec_addr   = aw_addr_r;
        rec_opcode = aw_size_r[2] ? nbf_opcode_width_p'(3)
                                  : nbf_opcode_width_p'(aw_size_r[1:0]);
        rec_data   = '0;
        case (aw_size_r)
            3'd0:    rec_data[7:0]  = w_data_r[{aw_addr_r[2:0], 3'b000} +: 8];
            3'd1:    rec_data[15:0] = w_data_r[{aw_addr_r[2:1], 4'b0000} +: 16];
            3'd2:    rec_data[31:0] = w_data_r[{aw_addr_r[2], 5'b00000} +: 32];
            default: rec_data       = w_data_r;
        endcase
    end

    // Flit selection. The record is held in registers for the whole packet,
    // so the selected flit is stable while the host stalls.
    always_comb begin
        io_data_o = '0;
        case (flit_cnt_r)
            3'd0:    io_data_o = rec_data[31:0];
            3'd1:    io_data_o = rec_data[63:32];
            3'd2:    io_data_o = rec_addr[31:0];
            3'd3:    io_data_o = rec_addr[63:32];
            default: io_data_o = {{(fifo_data_width_p-nbf_opcode_width_p){1'b0}}, rec_opcode};
        endcase
    end

endmodule

// File: tb/tb_blackparrot_fpga_host_io_out.sv
// tb_blackparrot_fpga_host_io_out
// Directed bench for the host I/O-out bridge. It checks flit packets,
// write/read responses, host back-pressure and asynchronous reset.
module tb_blackparrot_fpga_host_io_out;

    logic        s_axi_aclk = 1'b0;
    logic        s_axi_aresetn = 1'b1;

    logic [63:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [3:0]  s_axi_awid;
    logic        s_axi_awlock;
    logic [3:0]  s_axi_awcache;
    logic [2:0]  s_axi_awprot;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic [3:0]  s_axi_awqos;
    logic [3:0]  s_axi_awregion;
    logic [63:0] s_axi_wdata;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic        s_axi_wlast;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic [63:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [3:0]  s_axi_arid;
    logic        s_axi_arlock;
    logic [3:0]  s_axi_arcache;
    logic [2:0]  s_axi_arprot;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic [3:0]  s_axi_arqos;
    logic [3:0]  s_axi_arregion;
    logic [63:0] s_axi_rdata;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [3:0]  s_axi_rid;
    logic        s_axi_rlast;
    logic [1:0]  s_axi_rresp;
    logic        io_v_o;
    logic [31:0] io_data_o;
    logic        io_ready_and_i = 1'b1;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] flits[$];
    int          b_cnt = 0;
    int          ar_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_data = '0;
    logic        toggle_en = 1'b0;
    logic        ready_level = 1'b1;

    blackparrot_fpga_host_io_out dut (
        .s_axi_aclk     (s_axi_aclk),
        .s_axi_aresetn  (s_axi_aresetn),
        .s_axi_awaddr   (s_axi_awaddr),
        .s_axi_awvalid  (s_axi_awvalid),
        .s_axi_awready  (s_axi_awready),
        .s_axi_awid     (s_axi_awid),
        .s_axi_awlock   (s_axi_awlock),
        .s_axi_awcache  (s_axi_awcache),
        .s_axi_awprot   (s_axi_awprot),
        .s_axi_awlen    (s_axi_awlen),
        .s_axi_awsize   (s_axi_awsize),
        .s_axi_awburst  (s_axi_awburst),
        .s_axi_awqos    (s_axi_awqos),
        .s_axi_awregion (s_axi_awregion),
        .s_axi_wdata    (s_axi_wdata),
        .s_axi_wvalid   (s_axi_wvalid),
        .s_axi_wready   (s_axi_wready),
        .s_axi_wlast    (s_axi_wlast),
        .s_axi_wstrb    (s_axi_wstrb),
        .s_axi_bvalid   (s_axi_bvalid),
        .s_axi_bready   (s_axi_bready),
        .s_axi_bid      (s_axi_bid),
        .s_axi_bresp    (s_axi_bresp),
        .s_axi_araddr   (s_axi_araddr),
        .s_axi_arvalid  (s_axi_arvalid),
        .s_axi_arready  (s_axi_arready),
        .s_axi_arid     (s_axi_arid),
        .s_axi_arlock   (s_axi_arlock),
        .s_axi_arcache  (s_axi_arcache),
        .s_axi_arprot   (s_axi_arprot),
        .s_axi_arlen    (s_axi_arlen),
        .s_axi_arsize   (s_axi_arsize),
        .s_axi_arburst  (s_axi_arburst),
        .s_axi_arqos    (s_axi_arqos),
        .s_axi_arregion (s_axi_arregion),
        .s_axi_rdata    (s_axi_rdata),
        .s_axi_rvalid   (s_axi_rvalid),
        .s_axi_rready   (s_axi_rready),
        .s_axi_rid      (s_axi_rid),
        .s_axi_rlast    (s_axi_rlast),
        .s_axi_rresp    (s_axi_rresp),
        .io_v_o         (io_v_o),
        .io_data_o      (io_data_o),
        .io_ready_and_i (io_ready_and_i)
    );

    // 10ns clock
    initial forever #5 s_axi_aclk = ~s_axi_aclk;

    // Host-side ready. It either follows a fixed level or toggles every cycle.
    initial forever begin
        @(posedge s_axi_aclk);
        #1;
        io_ready_and_i = toggle_en ? ~io_ready_and_i : ready_level;
    end

    // Global time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Compare one observed value against its expected value and log any mismatch
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor at the falling edge. It collects accepted flits and counts B and AR handshakes.
    // A stalled flit must stay valid and unchanged.
    always @(negedge s_axi_aclk) begin
        if (pend) begin
            checkOutput("stall_valid", {63'd0, io_v_o}, 64'd1);
            checkOutput("stall_data", {32'd0, io_data_o}, {32'd0, pend_data});
        end
        pend      = io_v_o & ~io_ready_and_i;
        pend_data = io_data_o;
        if (io_v_o && io_ready_and_i) flits.push_back(io_data_o);
        if (s_axi_bvalid && s_axi_bready) b_cnt++;
        if (s_axi_arvalid && s_axi_arready) ar_cnt++;
    end

    // Offer an AW/W pair. W goes first by w_lead cycles. Each valid drops after its handshake.
    task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] data,
                                 input logic [2:0] size, input logic [7:0] len,
                                 input logic last, input logic [3:0] id, input int w_lead);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_hs, w_hs;
        int cyc = 0;
        s_axi_awaddr  = addr;
        s_axi_awsize  = size;
        s_axi_awlen   = len;
        s_axi_awid    = id;
        s_axi_wdata   = data;
        s_axi_wlast   = last;
        s_axi_wvalid  = 1'b1;
        s_axi_awvalid = (w_lead == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge s_axi_aclk);
            aw_hs = s_axi_awvalid & s_axi_awready;
            w_hs  = s_axi_wvalid & s_axi_wready;
            @(posedge s_axi_aclk);
            #1;
            if (aw_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  s_axi_wvalid  = 1'b0; end
            cyc++;
            if (cyc >= w_lead && !aw_done) s_axi_awvalid = 1'b1;
        end
        if (!(aw_done && w_done)) checkOutput("aw_w_handshake_timeout", 64'd0, 64'd1);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
    endtask

    // Offer one extra W beat, as needed for a burst
    task automatic sendBeat(input logic [63:0] data, input logic last);
        bit hs = 0;
        s_axi_wdata  = data;
        s_axi_wlast  = last;
        s_axi_wvalid = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge s_axi_aclk);
            hs = s_axi_wready;
            @(posedge s_axi_aclk);
            #1;
        end
        s_axi_wvalid = 1'b0;
        if (!hs) checkOutput("w_beat_timeout", 64'd0, 64'd1);
    endtask

    // Wait for B and check its resp and id. Return the falling edges counted until bvalid.
    task automatic waitResp(input string tag, input logic [1:0] resp, input logic [3:0] id, output int ncyc);
        bit seen = 0;
        ncyc = 0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            @(negedge s_axi_aclk);
            if (s_axi_bvalid) begin
                seen = 1;
                ncyc = i;
                checkOutput({tag, "_bresp"}, {62'd0, s_axi_bresp}, {62'd0, resp});
                checkOutput({tag, "_bid"}, {60'd0, s_axi_bid}, {60'd0, id});
                @(posedge s_axi_aclk);
                #1;
            end
        end
        if (!seen) checkOutput({tag, "_b_timeout"}, 64'd0, 64'd1);
    endtask

    // Compare the collected flits against a hand-computed five-flit packet
    task automatic checkPacket(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e4);
        logic [31:0] exp_flit[5];
        exp_flit = '{e0, e1, e2, e3, e4};
        checkOutput({tag, "_nflits"}, 64'(flits.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            if (i < flits.size())
                checkOutput($sformatf("%s_flit%0d", tag, i), {32'd0, flits[i]}, {32'd0, exp_flit[i]});
        flits.delete();
    endtask

    // Directed test sequence
    initial begin
        int n;
        int b0;
        bit hs;
        s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_awid = '0; s_axi_awlock = 0;
        s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = 2'b01; s_axi_awqos = '0; s_axi_awregion = '0;
        s_axi_wdata = '0; s_axi_wvalid = 0; s_axi_wlast = 0; s_axi_wstrb = 8'hFF;
        s_axi_bready = 1;
        s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_arid = '0; s_axi_arlock = 0;
        s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arlen = '0; s_axi_arsize = 3'd3;
        s_axi_arburst = 2'b01; s_axi_arqos = '0; s_axi_arregion = '0;
        s_axi_rready = 1;

        #1 s_axi_aresetn = 1'b0;
        #3;
        checkOutput("rst_awready", {63'd0, s_axi_awready}, 64'd0);
        checkOutput("rst_wready",  {63'd0, s_axi_wready},  64'd0);
        checkOutput("rst_arready", {63'd0, s_axi_arready}, 64'd0);
        checkOutput("rst_bvalid",  {63'd0, s_axi_bvalid},  64'd0);
        checkOutput("rst_rvalid",  {63'd0, s_axi_rvalid},  64'd0);
        checkOutput("rst_io_v",    {63'd0, io_v_o},        64'd0);
        checkOutput("rst_bresp",   {62'd0, s_axi_bresp},   64'd0);
        checkOutput("rst_bid",     {60'd0, s_axi_bid},     64'd0);
        repeat (2) @(posedge s_axi_aclk);
        @(negedge s_axi_aclk) s_axi_aresetn = 1'b1;
        repeat (2) @(posedge s_axi_aclk);
        #1;

        // 64b write with the host always ready
        applyStimulus(64'h0000_0000_0010_3000, 64'h1122_3344_5566_7788, 3'd3, 8'd0, 1'b1, 4'h3, 0);
        waitResp("t1", 2'b00, 4'h3, n);
        checkOutput("t1_latency", 64'(n), 64'd6);
        checkPacket("t1", 32'h5566_7788, 32'h1122_3344, 32'h0010_3000, 32'h0, 32'h3);

        // 32b write to the upper lane
        applyStimulus(64'h0000_0000_0010_1004, 64'hAAAA_BBBB_0000_0041, 3'd2, 8'd0, 1'b1, 4'h7, 0);
        waitResp("t2", 2'b00, 4'h7, n);
        checkPacket("t2", 32'hAAAA_BBBB, 32'h0, 32'h0010_1004, 32'h0, 32'h2);

        // Byte write to lane 3, then halfword write to lane 3
        applyStimulus(64'h0000_0000_0010_0003, 64'h1122_3344_5566_7788, 3'd0, 8'd0, 1'b1, 4'h1, 0);
        waitResp("t_b", 2'b00, 4'h1, n);
        checkPacket("t_b", 32'h0000_0055, 32'h0, 32'h0010_0003, 32'h0, 32'h0);
        applyStimulus(64'h0000_0000_0010_0006, 64'h1122_3344_5566_7788, 3'd1, 8'd0, 1'b1, 4'h2, 0);
        waitResp("t_h", 2'b00, 4'h2, n);
        checkPacket("t_h", 32'h0000_1122, 32'h0, 32'h0010_0006, 32'h0, 32'h1);

        // W goes three cycles before AW, and the host ready toggles every cycle
        b0 = b_cnt;
        toggle_en = 1'b1;
        applyStimulus(64'h0000_0001_8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 3'd3, 8'd0, 1'b1, 4'hA, 3);
        waitResp("t3", 2'b00, 4'hA, n);
        toggle_en = 1'b0;
        repeat (3) @(posedge s_axi_aclk);
        #1;
        checkPacket("t3", 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h8000_0010, 32'h0000_0001, 32'h3);
        checkOutput("t3_bcount", 64'(b_cnt - b0), 64'd1);
        checkOutput("t3_bvalid_low", {63'd0, s_axi_bvalid}, 64'd0);

        // Two-beat burst: it is drained and answered with SLVERR, and no flits are sent
        applyStimulus(64'h0000_0000_0000_2000, 64'h0123_4567_89AB_CDEF, 3'd3, 8'd1, 1'b0, 4'h2, 0);
        sendBeat(64'h0, 1'b1);
        waitResp("t4", 2'b10, 4'h2, n);
        checkOutput("t4_nflits", 64'(flits.size()), 64'd0);
        flits.delete();

        // Burst whose only beat already carries wlast gets SLVERR right away
        applyStimulus(64'h0000_0000_0000_2008, 64'h0, 3'd3, 8'd2, 1'b1, 4'h6, 0);
        waitResp("t4b", 2'b10, 4'h6, n);
        checkOutput("t4b_nflits", 64'(flits.size()), 64'd0);
        flits.delete();

        // AW and AR together: the write finishes first, then the read is served
        s_axi_arid    = 4'h5;
        s_axi_araddr  = 64'h0000_0000_0010_0000;
        s_axi_arvalid = 1'b1;
        applyStimulus(64'h0000_0000_0010_3000, 64'h0000_0000_0000_0021, 3'd3, 8'd0, 1'b1, 4'h9, 0);
        waitResp("t5", 2'b00, 4'h9, n);
        checkOutput("t5_ar_after_b", 64'(ar_cnt), 64'd0);
        checkPacket("t5", 32'h0000_0021, 32'h0, 32'h0010_3000, 32'h0, 32'h3);
        hs = 0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge s_axi_aclk);
            hs = s_axi_arready;
            @(posedge s_axi_aclk);
            #1;
        end
        s_axi_arvalid = 1'b0;
        checkOutput("t5_ar_accepted", {63'd0, hs}, 64'd1);
        hs = 0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge s_axi_aclk);
            if (s_axi_rvalid) begin
                hs = 1;
                checkOutput("t5_rdata", s_axi_rdata, 64'd0);
                checkOutput("t5_rlast", {63'd0, s_axi_rlast}, 64'd1);
                checkOutput("t5_rid",   {60'd0, s_axi_rid},   64'd5);
                checkOutput("t5_rresp", {62'd0, s_axi_rresp}, 64'd0);
                @(posedge s_axi_aclk);
                #1;
            end
        end
        checkOutput("t5_r_seen", {63'd0, hs}, 64'd1);

        // Reset during flit 2 drops io_v_o at once, and the next packet starts from flit 0
        applyStimulus(64'h0000_0000_0010_3000, 64'h1122_3344_5566_7788, 3'd3, 8'd0, 1'b1, 4'h4, 0);
        repeat (2) begin @(posedge s_axi_aclk); #1; end
        checkOutput("t6_pre_rst_data", {32'd0, io_data_o}, 64'h0010_3000);
        #2 s_axi_aresetn = 1'b0;
        #1;
        checkOutput("t6_rst_io_v",   {63'd0, io_v_o},       64'd0);
        checkOutput("t6_rst_bvalid", {63'd0, s_axi_bvalid}, 64'd0);
        repeat (2) @(posedge s_axi_aclk);
        @(negedge s_axi_aclk) s_axi_aresetn = 1'b1;
        repeat (2) @(posedge s_axi_aclk);
        #1;
        flits.delete();
        applyStimulus(64'h0000_0000_0010_3040, 64'h8877_6655_4433_2211, 3'd3, 8'd0, 1'b1, 4'h8, 0);
        waitResp("t6", 2'b00, 4'h8, n);
        checkPacket("t6", 32'h4433_2211, 32'h8877_6655, 32'h0010_3040, 32'h0, 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blackparrot_fpga_host_io_out.md
Name: blackparrot_fpga_host_io_out

Overview:
AXI4 subordinate that sits on BlackParrot's I/O-out port and terminates BP-initiated accesses to the host region (putchar, finish, status writes). Each accepted single-beat write is packed into an NBF-format record {opcode, addr, data} and serialized as 32b flits onto a valid/ready FIFO interface toward the host. It is the host-bound counterpart of the host-to-BP NBF path, and uses the same record layout so host software can reuse its NBF parser. Reads are answered locally with zero data.

Parameters:
S_AXI_ADDR_WIDTH, 64, AXI address width; must be 64.
S_AXI_DATA_WIDTH, 64, AXI data width; must be 64.
S_AXI_ID_WIDTH, 4, AXI ID width.
fifo_data_width_p, 32, host FIFO flit width; must be 32.
nbf_opcode_width_p, 8, record opcode width.
nbf_addr_width_p, 64, record address width; must be 64.
nbf_data_width_p, 64, record data width; must be 64.

Ports:
s_axi_aclk  in  1  clock.
s_axi_aresetn  in  1  reset; asynchronous assert, active-low.
s_axi_aw{addr,valid,ready,id,lock,cache,prot,len,size,burst,qos,region}  in/out(ready)  standard AXI4 widths  write address channel.
s_axi_w{data,valid,ready,last,strb}  in/out(ready)  64/1/1/1/8  write data channel.
s_axi_b{valid,ready,id,resp}  out/in(ready)/out/out  1/1/ID/2  write response.
s_axi_ar{addr,valid,ready,id,lock,cache,prot,len,size,burst,qos,region}  in/out(ready)  standard AXI4 widths  read address channel.
s_axi_r{data,valid,ready,id,last,resp}  out/in(ready)/out  64/1/1/ID/1/2  read data channel.
io_v_o  out  1  flit valid to host.
io_data_o  out  32  flit payload.
io_ready_and_i  in  1  host accepts flit (ready-and handshake).

Behaviour:
- Reset (async, aresetn=0): FSM to IDLE; aw/w holding regs empty; flit counter 0. Outputs: awready=wready=arready=0, bvalid=0, rvalid=0, io_v_o=0, resp/id/data outputs 0. A partially sent packet is discarded; the host side is reset together.
- FSM states: IDLE, DRAIN, SEND, BRESP, RRESP.
- IDLE:
  - awready = ~aw_full; wready = ~w_full. AW and W are captured independently, in either order or in the same cycle. Captured AW fields: id, addr, len, size. Captured W fields: data, last.
  - When aw_full & w_full:
    - If len==0: go to SEND.
    - If len!=0 and captured wlast=0: go to DRAIN.
    - If len!=0 and captured wlast=1: go to BRESP with SLVERR.
  - arready = 1 only when aw_full=0, w_full=0, awvalid=0 and wvalid=0 (writes have priority). AR handshake captures arid and goes to RRESP.
- DRAIN: wready=1; beats are discarded. The beat with wlast=1 moves the FSM to BRESP with resp=2'b10.
- Record build (combinational from holding regs):
  - Opcode = {6'b0, size[1:0]}, i.e. size 0..3 maps to 8'h00..8'h03. Size >3 is unsupported; the block sends opcode 8'h03.
  - data = addressed lane zero-extended. size 3: full 64b. size 2: lane addr[2]. size 1: lane addr[2:1]. size 0: lane addr[2:0].
  - addr = awaddr unmodified. wstrb is ignored.
- SEND: io_v_o=1. Flit k = record bits [32k+:32], k=0..4, LSB first:
  - k=0: data[31:0]
  - k=1: data[63:32]
  - k=2: addr[31:0]
  - k=3: addr[63:32]
  - k=4: {24'b0, opcode}
  - The counter advances only on io_v_o & io_ready_and_i. Handshake on k=4 → BRESP with resp OKAY (2'b00). io_v_o never drops and io_data_o never changes while a flit is pending.
- BRESP: bvalid=1, bid=captured awid, bresp held stable until bready. Handshake clears aw_full/w_full and returns to IDLE. Earliest next awready is the cycle after the B handshake.
- RRESP: rvalid=1, rdata=0, rresp=OKAY, rlast=1, rid=captured arid; held until rready, then IDLE. arlen is ignored; always one beat.
- Latency: with io_ready_and_i tied 1, AW+W in cycle 0 → flits in cycles 1..5 → bvalid in cycle 6.
- Constant outputs: none on the subordinate side beyond the above. Only one transaction is outstanding at any time.

Test Plan:
- 64b write, addr 0x0010_3000, data 0x1122_3344_5566_7788, size 3, ready=1 → flits 0x55667788, 0x11223344, 0x00103000, 0x00000000, 0x00000003; bresp 0 with bid echoed.
- 32b write, addr 0x0010_1004, data 0xAAAA_BBBB_0000_0041, size 2 → flit0=0xAAAABBBB, flit1=0, flit4=0x00000002.
- W presented 3 cycles before AW; io_ready_and_i toggled 1/0 per cycle → flit order and values identical, io_data_o stable while stalled, single bvalid.
- Burst awlen=1, two W beats → no io_v_o; bresp=2'b10 after second (wlast) beat.
- awvalid and arvalid asserted together in IDLE → write completes (B) first; then AR accepted, rdata=0, rlast=1, rid matches.
- aresetn pulsed low during flit 2 → io_v_o=0 immediately (async); after release, a new 64b write emits a complete 5-flit packet from flit 0.
